id_exe_reg: RTL

- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM pipeline.
- Captures every decode-stage output on each rising clock edge, along with the forwarding source IDs and the current carry flag.
- Presents the captured values to the execute stage for one full cycle.
- Supports hazard freeze (hold), branch flush (insert bubble), and a valid bit that marks real instructions versus bubbles.

---
 rtl/id_exe_reg.sv | 107 ++++++++++
 1 files changed

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register for the 5-stage ARM pipeline.
// Holds the decoded instruction, operands, forwarding source IDs and carry
// flag for the execute stage. Supports hold on hazard and bubble on flush.
module id_exe_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,

    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] PC_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  wb_en_in,
    input  logic                  status_w_en_in,
    input  logic                  branch_taken_in,
    input  logic                  imm_in,
    input  logic [3:0]            exec_cmd_in,
    input  logic [DATA_WIDTH-1:0] val_rn_in,
    input  logic [DATA_WIDTH-1:0] val_rm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [23:0]           signed_immed_24_in,
    input  logic [3:0]            dest_in,
    input  logic [3:0]            src1_in,
    input  logic [3:0]            src2_in,
    input  logic                  carry_in,

    output logic                  valid,
    output logic [DATA_WIDTH-1:0] PC,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic                  wb_en,
    output logic                  status_w_en,
    output logic                  branch_taken,
    output logic                  imm,
    output logic [3:0]            exec_cmd,
    output logic [DATA_WIDTH-1:0] val_rn,
    output logic [DATA_WIDTH-1:0] val_rm,
    output logic [11:0]           shift_operand,
    output logic [23:0]           signed_immed_24,
    output logic [3:0]            dest,
    output logic [3:0]            src1,
    output logic [3:0]            src2,
    output logic                  carry
);

    // Side-effecting control bits are only honoured for real instructions.
    logic mem_r_en_gated;
    logic mem_w_en_gated;
    logic wb_en_gated;
    logic status_w_en_gated;
    logic branch_taken_gated;

    // Mask state-changing controls of a non-valid decode entry.
    always_comb begin
        mem_r_en_gated     = mem_r_en_in     & valid_in;
        mem_w_en_gated     = mem_w_en_in     & valid_in;
        wb_en_gated        = wb_en_in        & valid_in;
        status_w_en_gated  = status_w_en_in  & valid_in;
        branch_taken_gated = branch_taken_in & valid_in;
    end

    // Pipeline register: reset and flush both load an all-zero bubble,
    // freeze holds, otherwise capture the decode stage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid           <= 1'b0;
            PC              <= '0;
            mem_r_en        <= 1'b0;
            mem_w_en        <= 1'b0;
            wb_en           <= 1'b0;
            status_w_en     <= 1'b0;
            branch_taken    <= 1'b0;
            imm             <= 1'b0;
            exec_cmd        <= '0;
            val_rn          <= '0;
            val_rm          <= '0;
            shift_operand   <= '0;
            signed_immed_24 <= '0;
            dest            <= '0;
            src1            <= '0;
            src2            <= '0;
            carry           <= 1'b0;
        end else if (!freeze) begin
            valid           <= valid_in;
            PC              <= PC_in;
            mem_r_en        <= mem_r_en_gated;
            mem_w_en        <= mem_w_en_gated;
            wb_en           <= wb_en_gated;
            status_w_en     <= status_w_en_gated;
            branch_taken    <= branch_taken_gated;
            imm             <= imm_in;
            exec_cmd        <= exec_cmd_in;
            val_rn          <= val_rn_in;
            val_rm          <= val_rm_in;
            shift_operand   <= shift_operand_in;
            signed_immed_24 <= signed_immed_24_in;
            dest            <= dest_in;
            src1            <= src1_in;
            src2            <= src2_in;
            carry           <= carry_in;
        end
    end

endmodule
